phi_diag_collector: RTL and testbench
=====================================

Name: phi_diag_collector

Overview:
Downstream stage of the per-channel predicted-covariance adders (P_ii = Theta_ii + Q_ii). Captures the serial stream of diagonal results (a, valid) into an NUM_DIAG-entry register vector. Presents the full vector to the gain stage with a valid/ready handshake. Flags protocol violations: results arriving when no frame is open, and results arriving while a completed vector is still unconsumed.

Parameters:
DBL_WIDTH, 64, IEEE-754 double width of each entry
NUM_DIAG, 12, number of diagonal entries per frame (>=2)
IDX_W, $clog2(NUM_DIAG), width of the write index (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  open new frame; index to 0, error flags cleared
a_in  input  DBL_WIDTH  diagonal result from upstream adder channel
a_valid  input  1  a_in valid this cycle (single-cycle pulses, back-to-back allowed)
out_ready  input  1  gain stage accepts diag_vec
diag_vec  output  NUM_DIAG*DBL_WIDTH  entry i at bits [i*DBL_WIDTH +: DBL_WIDTH]
out_valid  output  1  diag_vec complete and stable
busy  output  1  frame open (state COLLECT)
wr_idx  output  IDX_W  next entry index to be written
overflow_err  output  1  sticky: a_valid in HOLD, data dropped
stray_err  output  1  sticky: a_valid in IDLE, data dropped
nan_flag  output  1  see Optional Feature

Behaviour:
- Reset (async, rst_n=0): state IDLE; diag_vec, wr_idx, out_valid, busy, both error flags, nan_flag all 0.
- States: IDLE, COLLECT, HOLD. busy = (COLLECT); out_valid = (HOLD); both registered.
- IDLE: start -> COLLECT, wr_idx=0, errors cleared. a_valid without start -> dropped, stray_err=1.
- IDLE with start and a_valid same cycle: start wins, a_in dropped, stray_err not set. The new frame begins the next cycle.
- COLLECT: a_valid -> diag_vec[wr_idx] <= a_in, wr_idx++.
- COLLECT, write at wr_idx==NUM_DIAG-1: wr_idx wraps to 0, state -> HOLD. out_valid is high the cycle after that write.
- COLLECT with start: restart; wr_idx=0, state stays COLLECT. Concurrent a_valid is dropped. Entries already written are not cleared and are overwritten as the new frame fills.
- HOLD: diag_vec frozen. out_valid && out_ready -> IDLE, or -> COLLECT if start is asserted the same cycle.
- HOLD, a_valid: dropped, overflow_err=1. diag_vec is unchanged.
- HOLD, start without out_ready: ignored. Frame is not lost.
- Latency: a_valid at edge t -> entry visible at t+1. Last entry at t -> out_valid at t+1. Handshake at t -> out_valid=0 at t+1.
- No arithmetic on data; bits are copied verbatim, no rounding or reordering.
- Error flags are cleared only by reset or by an accepted start.
- rst_n asserted mid-frame: all state discarded immediately, no partial output.

Optional Feature:
Macro PHI_COLLECT_NANCHK_EN.
- Defined: each accepted entry is classified. Exponent all ones (NaN or Inf) sets nan_flag (sticky). nan_flag is cleared on accepted start and is meaningful while out_valid=1.
- Not defined: nan_flag tied to 0, no classification logic. All other behaviour identical.

Decomposition:
- Shared package kalman_pkg holds DBL_WIDTH, the state enum (IDLE/COLLECT/HOLD), and function fp_is_nan_inf(logic [63:0]).
- One small sub-module is natural: fp_class_chk (combinational NaN/Inf detect). Instantiated only under PHI_COLLECT_NANCHK_EN.
- Index counter and FSM stay inline.

Test Plan:
- Reset, start, then 12 back-to-back a_valid with a_in=64'h3FF0_0000_0000_0000+i: after the last write, out_valid=1 next cycle, entry i = 3FF0...+i, busy=0, errors 0.
- Frame complete, out_ready=0 for 5 cycles, 2 extra a_valid: diag_vec unchanged, overflow_err=1. out_ready=1 -> out_valid=0 next cycle, state IDLE.
- a_valid in IDLE (no start): stray_err=1, diag_vec=0. Then start: stray_err=0, busy=1, wr_idx=0.
- Start, 5 entries, start again, 12 entries with new values: entries 0..11 hold the second-frame values, out_valid asserts once.
- Handshake and start in the same HOLD cycle: out_valid falls, busy=1 next cycle. Restart mid-frame and async rst_n mid-frame: all outputs 0 within the reset cycle.
- NANCHK_EN build: entry 3 = 64'h7FF8_0000_0000_0000 -> nan_flag=1 at out_valid. Non-EN build, same stimulus: nan_flag=0.

Source files
------------

// File: rtl/kalman_pkg.sv
// kalman_pkg: shared width, collector FSM states and the IEEE-754 NaN/Inf classifier
package kalman_pkg;
  localparam int DBL_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  function automatic logic fp_is_nan_inf(input logic [63:0] x);
    return &x[62:52];
  endfunction
endpackage

// File: rtl/fp_class_chk.sv
// fp_class_chk: flags a double whose exponent is all ones (NaN or Inf)
module fp_class_chk
  import kalman_pkg::*;
(
  input  logic [63:0] x,
  output logic        is_nan_inf
);
  assign is_nan_inf = fp_is_nan_inf(x);
endmodule

// File: rtl/phi_diag_collector.sv
// phi_diag_collector: gathers NUM_DIAG serial P_ii results into a vector with valid/ready output; PHI_COLLECT_NANCHK_EN adds sticky NaN/Inf detection
module phi_diag_collector
  import kalman_pkg::*;
#(
  parameter  int DBL_WIDTH = kalman_pkg::DBL_WIDTH,
  parameter  int NUM_DIAG  = 12,
  localparam int IDX_W     = $clog2(NUM_DIAG)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DBL_WIDTH-1:0]          a_in,
  input  logic                          a_valid,
  input  logic                          out_ready,
  output logic [NUM_DIAG*DBL_WIDTH-1:0] diag_vec,
  output logic                          out_valid,
  output logic                          busy,
  output logic [IDX_W-1:0]              wr_idx,
  output logic                          overflow_err,
  output logic                          stray_err,
  output logic                          nan_flag
);
  state_t state_q, state_d;
  logic clr, wr_en, ovf_set, stray_set, last;
  assign last      = wr_idx == IDX_W'(NUM_DIAG - 1);
  assign busy      = state_q == COLLECT;
  assign out_valid = state_q == HOLD;
  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    wr_en     = 1'b0;
    ovf_set   = 1'b0;
    stray_set = 1'b0;
    case (state_q)
      IDLE: begin
        clr       = start;
        stray_set = a_valid && !start;
        state_d   = start ? COLLECT : IDLE;
      end
      COLLECT: begin
        clr     = start;
        wr_en   = a_valid && !start;
        state_d = (wr_en && last) ? HOLD : COLLECT;
      end
      HOLD: begin
        clr     = out_ready && start;
        ovf_set = a_valid;
        state_d = out_ready ? (start ? COLLECT : IDLE) : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_idx       <= '0;
      overflow_err <= 1'b0;
      stray_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx       <= (clr || (wr_en && last)) ? '0 : wr_en ? wr_idx + 1'b1 : wr_idx;
      overflow_err <= clr ? 1'b0 : overflow_err | ovf_set;
      stray_err    <= clr ? 1'b0 : stray_err | stray_set;
    end
  for (genvar g = 0; g < NUM_DIAG; g++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) diag_vec[g*DBL_WIDTH +: DBL_WIDTH] <= '0;
      else if (wr_en && wr_idx == IDX_W'(g)) diag_vec[g*DBL_WIDTH +: DBL_WIDTH] <= a_in;
  end
`ifdef PHI_COLLECT_NANCHK_EN
  logic nan_hit;
  fp_class_chk u_chk (.x(a_in), .is_nan_inf(nan_hit));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nan_flag <= 1'b0;
    else nan_flag <= clr ? 1'b0 : nan_flag | (wr_en && nan_hit);
`else
  assign nan_flag = 1'b0;
`endif
endmodule

// File: tb/tb_phi_diag_collector.sv
// tb_phi_diag_collector: table-driven and directed checks of phi_diag_collector
module tb_phi_diag_collector;
  localparam int N = 12;
  localparam int W = 64;
  logic clk = 0, rst_n = 0, start = 0, a_valid = 0, out_ready = 0;
  logic [W-1:0] a_in = '0;
  logic [N*W-1:0] diag_vec;
  logic out_valid, busy, overflow_err, stray_err, nan_flag;
  logic [3:0] wr_idx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  phi_diag_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .a_valid(a_valid),
    .out_ready(out_ready), .diag_vec(diag_vec), .out_valid(out_valid), .busy(busy),
    .wr_idx(wr_idx), .overflow_err(overflow_err), .stray_err(stray_err), .nan_flag(nan_flag)
  );
  typedef struct {
    logic s, v, r;
    logic [63:0] d;
    logic ov, bz;
    logic [3:0] idx;
    logic ovf, stray, vchk;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_vec(input string nm, input logic [N*W-1:0] exp);
    checks++;
    if (diag_vec !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, diag_vec, exp);
    end
  endtask
  task automatic step(input logic s, input logic v, input logic r, input logic [63:0] d);
    @(negedge clk);
    start = s; a_valid = v; out_ready = r; a_in = d;
    @(posedge clk);
    #1;
  endtask
  logic [N*W-1:0] ref_vec, ref2;
  logic exp_nan;
  int early;
  initial begin
    for (int i = 0; i < N; i++) ref_vec[i*W +: W] = 64'h3FF0_0000_0000_0000 + 64'(i);
    for (int i = 0; i < N; i++) ref2[i*W +: W] = 64'd200 + 64'(i);
    tbl.push_back('{0, 1, 0, 64'd5, 0, 0, 4'd0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 64'd0, 0, 1, 4'd0, 0, 0, 0});
    for (int i = 0; i < N; i++)
      tbl.push_back('{0, 1, 0, 64'h3FF0_0000_0000_0000 + 64'(i), i == N - 1, i != N - 1,
                      (i == N - 1) ? 4'd0 : 4'(i + 1), 0, 0, i == N - 1});
    tbl.push_back('{0, 1, 0, 64'hDEAD, 1, 0, 4'd0, 1, 0, 1});
    tbl.push_back('{0, 1, 0, 64'hBEEF, 1, 0, 4'd0, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 64'd0, 1, 0, 4'd0, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 64'd0, 1, 0, 4'd0, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 64'd0, 1, 0, 4'd0, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 64'd0, 0, 0, 4'd0, 1, 0, 1});
    #12;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_wr_idx", 64'(wr_idx), 0);
    chk("rst_errs", {62'd0, overflow_err, stray_err}, 0);
    chk("rst_nan", 64'(nan_flag), 0);
    chk_vec("rst_diag", '0);
    @(negedge clk) rst_n = 1;
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].v, tbl[i].r, tbl[i].d);
      chk($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].bz));
      chk($sformatf("row%0d_wr_idx", i), 64'(wr_idx), 64'(tbl[i].idx));
      chk($sformatf("row%0d_overflow", i), 64'(overflow_err), 64'(tbl[i].ovf));
      chk($sformatf("row%0d_stray", i), 64'(stray_err), 64'(tbl[i].stray));
      if (i == 0) chk_vec("row0_diag_zero", '0);
      if (tbl[i].vchk) chk_vec($sformatf("row%0d_diag", i), ref_vec);
    end
    step(1, 0, 0, 0);
    chk("restart_busy", 64'(busy), 1);
    chk("restart_ovf_clr", 64'(overflow_err), 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 64'd100 + 64'(i));
    chk("partial_idx", 64'(wr_idx), 5);
    step(1, 1, 0, 64'hFFFF);
    chk("midrestart_idx", 64'(wr_idx), 0);
    chk("midrestart_busy", 64'(busy), 1);
    early = 0;
    for (int i = 0; i < N; i++) begin
      step(0, 1, 0, 64'd200 + 64'(i));
      if (out_valid && i < N - 1) early++;
    end
    chk("second_frame_early_valid", 64'(early), 0);
    chk("second_frame_valid", 64'(out_valid), 1);
    chk_vec("second_frame_diag", ref2);
    step(1, 0, 1, 0);
    chk("hs_start_out_valid", 64'(out_valid), 0);
    chk("hs_start_busy", 64'(busy), 1);
    chk("hs_start_idx", 64'(wr_idx), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'd300 + 64'(i));
    chk("pre_rst_idx", 64'(wr_idx), 3);
    @(negedge clk);
    a_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_busy", 64'(busy), 0);
    chk("async_idx", 64'(wr_idx), 0);
    chk("async_out_valid", 64'(out_valid), 0);
    chk_vec("async_diag", '0);
    @(negedge clk) rst_n = 1;
`ifdef PHI_COLLECT_NANCHK_EN
    exp_nan = 1;
`else
    exp_nan = 0;
`endif
    step(1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, 0, (i == 3) ? 64'h7FF8_0000_0000_0000 : 64'h3FF0_0000_0000_0000);
    chk("nan_out_valid", 64'(out_valid), 1);
    chk("nan_flag", 64'(nan_flag), 64'(exp_nan));
    chk("nan_entry3", diag_vec[3*W +: W], 64'h7FF8_0000_0000_0000);
    step(0, 0, 1, 0);
    chk("nan_hs_out_valid", 64'(out_valid), 0);
    step(1, 0, 0, 0);
    chk("nan_cleared", 64'(nan_flag), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
